fir_out_buffer: RTL and testbench



---
 rtl/fir_out_buffer.sv | 149 ++++++++++++++
 tb/tb_fir_out_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_buffer.sv
// -----------------------------------------------------------------------------
// fir_out_buffer
//
// Output stage that follows the FIR filter. Once per output frame (N_TAPS clk
// cycles) it samples the filter output bus on a fixed phase. The first
// SKIP_FRAMES capture events after reset hold stale MAC results and are
// discarded. Accepted samples are queued in a small first-word-fall-through
// FIFO and offered on a valid/ready stream. Samples that arrive while the FIFO
// is full, and are not covered by a same-edge pop, are dropped. A drop sets a
// sticky flag and bumps a saturating counter.
//
// Ports:
//   clk          system clock, shared with the filter
//   rst          synchronous, active-high reset
//   fir_dout     filter output sample
//   m_data       head-of-FIFO sample
//   m_valid      m_data holds a valid sample
//   m_ready      consumer accepts m_data on this edge
//   level        FIFO occupancy, 0..FIFO_DEPTH
//   overflow     sticky: at least one sample dropped since reset
//   drop_count   saturating count of dropped samples
//   sample_tick  high during the capture cycle
// -----------------------------------------------------------------------------
module fir_out_buffer #(
   parameter int WIDTH_DATA    = 8,
   parameter int N_TAPS        = 16,
   parameter int CAPTURE_PHASE = 0,
   parameter int SKIP_FRAMES   = 2,
   parameter int FIFO_DEPTH    = 4,
   parameter int LOG2_DEPTH    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH_DATA-1:0] fir_dout,
   output logic [WIDTH_DATA-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [LOG2_DEPTH:0]   level,
   output logic                  overflow,
   output logic [7:0]            drop_count,
   output logic                  sample_tick
);

   localparam int PHASE_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int SKIP_W  = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

   localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(N_TAPS - 1);
   localparam logic [PHASE_W-1:0]  CAP_PHASE  = PHASE_W'(CAPTURE_PHASE);
   localparam logic [SKIP_W-1:0]   SKIP_INIT  = SKIP_W'(SKIP_FRAMES);
   localparam logic [LOG2_DEPTH:0] FULL_LEVEL = (LOG2_DEPTH + 1)'(FIFO_DEPTH);

   logic [PHASE_W-1:0]    phase_reg;
   logic [SKIP_W-1:0]     skip_reg;
   logic [LOG2_DEPTH-1:0] wr_ptr_reg;
   logic [LOG2_DEPTH-1:0] rd_ptr_reg;
   logic [LOG2_DEPTH:0]   level_reg;
   logic                  overflow_reg;
   logic [7:0]            drop_count_reg;
   logic [WIDTH_DATA-1:0] mem_reg [FIFO_DEPTH];

   logic push_req;
   logic pop;
   logic full;
   logic push_ok;
   logic drop;

   // ---------------------------------------------------------------- framing
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_reg <= '0;
      end else if (phase_reg == LAST_PHASE) begin
         phase_reg <= '0;
      end else begin
         phase_reg <= phase_reg + 1'b1;
      end
   end

   assign sample_tick = (phase_reg == CAP_PHASE) & ~rst;

   // Start-up frames carry stale accumulator contents; swallow them silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         skip_reg <= SKIP_INIT;
      end else if (sample_tick && (skip_reg != '0)) begin
         skip_reg <= skip_reg - 1'b1;
      end
   end

   // ------------------------------------------------------------ FIFO control
   assign push_req = sample_tick & (skip_reg == '0);
   assign pop      = m_valid & m_ready;
   assign full     = (level_reg == FULL_LEVEL);
   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign push_ok  = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push_ok && !pop) begin
            level_reg <= level_reg + 1'b1;
         end else if (pop && !push_ok) begin
            level_reg <= level_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (push_ok) begin
         mem_reg[wr_ptr_reg] <= fir_dout;
      end
   end

   // ------------------------------------------------------- drop accounting
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg   <= 1'b0;
         drop_count_reg <= '0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (drop_count_reg != 8'hFF) begin
            drop_count_reg <= drop_count_reg + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   // Fall-through read from registered state only: m_ready never reaches
   // m_valid or m_data combinationally.
   assign m_data     = mem_reg[rd_ptr_reg];
   assign m_valid    = (level_reg != '0);
   assign level      = level_reg;
   assign overflow   = overflow_reg;
   assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_fir_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_fir_out_buffer
//
// Directed scenarios plus a randomized stretch for fir_out_buffer. A reference
// model (edge counter, skip budget, sample queue, drop tally) predicts every
// output after every clock edge.
// -----------------------------------------------------------------------------
module tb_fir_out_buffer;

   localparam int WD = 8;
   localparam int NT = 16;
   localparam int CP = 0;
   localparam int SK = 2;
   localparam int FD = 4;
   localparam int LD = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [WD-1:0] fir_dout = '0;
   logic          m_ready = 1'b0;
   logic [WD-1:0] m_data;
   logic          m_valid;
   logic [LD:0]   level;
   logic          overflow;
   logic [7:0]    drop_count;
   logic          sample_tick;

   always #5 clk = ~clk;

   fir_out_buffer #(
      .WIDTH_DATA   (WD),
      .N_TAPS       (NT),
      .CAPTURE_PHASE(CP),
      .SKIP_FRAMES  (SK),
      .FIFO_DEPTH   (FD),
      .LOG2_DEPTH   (LD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fir_dout   (fir_dout),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count),
      .sample_tick(sample_tick)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   int            edge_cnt  = 0;
   int            skip_left = SK;
   logic [WD-1:0] q[$];
   int            drops     = 0;
   bit            ovf       = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check sample_tick before the edge, advance the model on the
   // edge, then check the registered outputs just after it.
   task automatic cycle();
      bit            cap;
      bit            pop;
      logic [WD-1:0] popped;
      #1;
      cap = !rst && ((edge_cnt % NT) == CP);
      check("sample_tick", sample_tick, cap);
      @(posedge clk);
      if (rst) begin
         q.delete();
         edge_cnt  = 0;
         skip_left = SK;
         drops     = 0;
         ovf       = 1'b0;
      end else begin
         pop = (q.size() > 0) && m_ready;
         if (pop) begin
            popped = q.pop_front();
            $display("pop  data=%02h t=%0t", popped, $time);
         end
         if (cap) begin
            if (skip_left > 0) begin
               skip_left--;
               $display("skip data=%02h t=%0t", fir_dout, $time);
            end else if (q.size() < FD) begin
               q.push_back(fir_dout);
               $display("push data=%02h t=%0t", fir_dout, $time);
            end else begin
               drops++;
               ovf = 1'b1;
               $display("drop data=%02h t=%0t", fir_dout, $time);
            end
         end
         edge_cnt++;
      end
      #1;
      check("m_valid", m_valid, (q.size() != 0));
      if (q.size() != 0) check("m_data", m_data, q[0]);
      check("level", level, q.size());
      check("overflow", overflow, ovf);
      check("drop_count", drop_count, (drops > 255) ? 255 : drops);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic to_capture();
      for (int g = 0; g < NT && (edge_cnt % NT) != CP; g++) cycle();
   endtask

   task automatic capture(input logic [WD-1:0] v, input logic rdy);
      to_capture();
      fir_dout = v;
      m_ready  = rdy;
      cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      check("rst_m_data", m_data, 0);
      rst = 1'b0;
   endtask

   initial begin
      // Startup skip
      m_ready  = 1'b1;
      fir_dout = 8'h5A;
      do_reset();
      run(32);
      cycle();
      check("startup_valid", m_valid, 1);
      check("startup_data", m_data, 8'h5A);
      cycle();
      check("startup_empty", m_valid, 0);
      check("startup_level", level, 0);

      // Fill and drop
      m_ready = 1'b0;
      do_reset();
      run(32);
      for (int i = 1; i <= 4; i++) capture(i[WD-1:0], 1'b0);
      check("fill_level", level, 4);
      capture(8'd5, 1'b0);
      check("fill_ovf", overflow, 1);
      check("fill_drops", drop_count, 1);
      m_ready = 1'b1;
      run(4);
      check("drain_empty", m_valid, 0);
      m_ready = 1'b0;

      // Full with simultaneous pop
      do_reset();
      run(32);
      for (int i = 1; i <= 4; i++) capture(i[WD-1:0], 1'b0);
      capture(8'd5, 1'b1);
      m_ready = 1'b0;
      check("fullpop_level", level, 4);
      check("fullpop_ovf", overflow, 0);
      check("fullpop_head", m_data, 2);
      m_ready = 1'b1;
      run(4);
      m_ready = 1'b0;

      // Back-pressure stability
      do_reset();
      run(32);
      capture(8'hC3, 1'b0);
      run(10);
      check("bp_data", m_data, 8'hC3);
      m_ready = 1'b1;
      cycle();
      check("bp_popped", m_valid, 0);
      m_ready = 1'b0;

      // Saturation
      do_reset();
      run(32);
      for (int f = 0; f < 300; f++) begin
         fir_dout = WD'($urandom);
         run(NT);
      end
      check("sat_level", level, 4);
      check("sat_drops", drop_count, 255);
      check("sat_ovf", overflow, 1);

      // Mid-run reset
      cycle();
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      check("mid_level", level, 3);
      do_reset();
      check("mid_rst_level", level, 0);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_drops", drop_count, 0);
      m_ready  = 1'b1;
      fir_dout = 8'h77;
      run(32);
      check("mid_skip_level", level, 0);
      run(16);

      // Randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         fir_dout = WD'($urandom);
         m_ready  = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 7) == 0) : 1'b1;
         if (i > 200 && i < 1200) m_ready = ($urandom_range(0, 31) == 0);
         rst = ($urandom_range(0, 699) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
